// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM traffic generator and its read checker:
// request-word layout, issue/check state encodings and small helpers.
package dram_pkg;

    // Request word is {addr, rw}; rw sits in bit 0, 1 means write.
    localparam int   REQ_RW_BIT = 0;
    localparam logic REQ_WRITE  = 1'b1;
    localparam logic REQ_READ   = 1'b0;

    typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} issue_state_e;
    typedef enum logic       {CHK, GAP}            chk_state_e;

    // Page-address width from memory size and page width.
    function automatic int addr_size(input int log_dram_size, input int page_len);
        return log_dram_size - $clog2(page_len);
    endfunction

    // Pack/unpack in a 32-bit container; callers size-cast to LOG_REQ_SIZE.
    function automatic logic [31:0] pack_req(input logic [30:0] addr, input logic rw);
        return {addr, rw};
    endfunction

    function automatic logic req_is_write(input logic [31:0] req);
        return req[REQ_RW_BIT] == REQ_WRITE;
    endfunction

endpackage

// File: rtl/dram_read_checker.sv
// Pops read data one word per two cycles, compares each word with its page
// address and keeps the sticky error, saturating count and first bad address.
module dram_read_checker
    import dram_pkg::*;
#(
    parameter int PAGE_LEN      = 32,
    parameter int LOG_ADDR_SIZE = 1,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     active,
    input  logic [PAGE_LEN-1:0]      rd_data,
    input  logic                     rd_empty,
    output logic                     rd_en,
    output logic                     error,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic [LOG_ADDR_SIZE-1:0] err_addr,
    output logic                     chk_done
);

    chk_state_e               phase;
    logic [LOG_ADDR_SIZE:0]   chk_cnt;    // one extra bit: reaching NPAGES sets the MSB
    logic [LOG_ADDR_SIZE-1:0] chk_addr;
    logic                     mismatch;

    assign chk_addr = chk_cnt[LOG_ADDR_SIZE-1:0];
    assign chk_done = chk_cnt[LOG_ADDR_SIZE];
    assign mismatch = rd_data != PAGE_LEN'(chk_addr);

    // Pop/compare handshake; the GAP cycle lets the FIFO empty flag settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= CHK;
            rd_en     <= 1'b0;
            chk_cnt   <= '0;
            error     <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else if (clear) begin
            phase     <= CHK;
            rd_en     <= 1'b0;
            chk_cnt   <= '0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            rd_en <= 1'b0;
            case (phase)
                CHK: if (active && !chk_done && !rd_empty) begin
                    rd_en   <= 1'b1;
                    chk_cnt <= chk_cnt + 1'b1;
                    phase   <= GAP;
                    if (mismatch) begin
                        error <= 1'b1;
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!error) err_addr <= chk_addr;
                    end
                end
                GAP:     phase <= CHK;
                default: phase <= CHK;
            endcase
        end
    end

endmodule

// File: rtl/dram_traffic_gen.sv
// Self-checking DRAM traffic source: writes every page with its own address,
// reads every page back and lets the read checker verify the returned data.
module dram_traffic_gen
    import dram_pkg::*;
#(
    parameter int LOG_DRAM_SIZE = 6,
    parameter int PAGE_LEN      = 32,
    parameter int LOG_ADDR_SIZE = LOG_DRAM_SIZE - $clog2(PAGE_LEN),
    parameter int LOG_REQ_SIZE  = 1 + LOG_ADDR_SIZE,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     frq_write_en,
    output logic [LOG_REQ_SIZE-1:0]  frq_write_data,
    input  logic                     frq_full,
    output logic                     fin_write_en,
    output logic [PAGE_LEN-1:0]      fin_write_data,
    input  logic                     fin_full,
    output logic                     fout_read_en,
    input  logic [PAGE_LEN-1:0]      fout_read_data,
    input  logic                     fout_empty,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic [LOG_ADDR_SIZE-1:0] err_addr
);

    localparam logic [LOG_ADDR_SIZE-1:0] LAST_ADDR = '1;

    issue_state_e             state;
    logic [LOG_ADDR_SIZE-1:0] addr;
    logic                     run_start;
    logic                     chk_active;
    logic                     chk_done;

    assign run_start  = (state == IDLE) && start;
    assign chk_active = (state == RD) || (state == DRAIN);

    // Issue FSM: write pass, read pass, then wait for the checker to finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            frq_write_en   <= 1'b0;
            frq_write_data <= '0;
            fin_write_en   <= 1'b0;
            fin_write_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            frq_write_en <= 1'b0;
            fin_write_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= WR;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    addr  <= '0;
                end
                WR: if (!frq_full && !fin_full) begin
                    frq_write_en   <= 1'b1;
                    frq_write_data <= LOG_REQ_SIZE'(pack_req(31'(addr), REQ_WRITE));
                    fin_write_en   <= 1'b1;
                    fin_write_data <= PAGE_LEN'(addr);
                    addr           <= addr + 1'b1;
                    if (addr == LAST_ADDR) state <= RD;
                end
                RD: if (!frq_full) begin
                    frq_write_en   <= 1'b1;
                    frq_write_data <= LOG_REQ_SIZE'(pack_req(31'(addr), REQ_READ));
                    addr           <= addr + 1'b1;
                    if (addr == LAST_ADDR) state <= DRAIN;
                end
                DRAIN: if (chk_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dram_read_checker #(
        .PAGE_LEN      (PAGE_LEN),
        .LOG_ADDR_SIZE (LOG_ADDR_SIZE),
        .ERR_CNT_W     (ERR_CNT_W)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .clear     (run_start),
        .active    (chk_active),
        .rd_data   (fout_read_data),
        .rd_empty  (fout_empty),
        .rd_en     (fout_read_en),
        .error     (error),
        .err_count (err_count),
        .err_addr  (err_addr),
        .chk_done  (chk_done)
    );

endmodule

// File: tb/tb_dram_traffic_gen.sv
// Bench for dram_traffic_gen with 16 pages: queue-based FIFOs, a memory
// responder with random stalls/backpressure, and page-corruption injection.
module tb_dram_traffic_gen;
    localparam int LDS = 9, PL = 32, LAS = 4, LRS = 5, EW = 16, N = 16;

    logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic           frq_write_en, fin_write_en, fout_read_en;
    logic [LRS-1:0] frq_write_data;
    logic [PL-1:0]  fin_write_data;
    logic           frq_full, fin_full;
    logic [PL-1:0]  fout_read_data = '0;
    logic           fout_empty = 1'b1;
    logic           busy, done, error;
    logic [EW-1:0]  err_count;
    logic [LAS-1:0] err_addr;

    always #5 clk = ~clk;

    dram_traffic_gen #(.LOG_DRAM_SIZE(LDS), .PAGE_LEN(PL), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .frq_write_en(frq_write_en), .frq_write_data(frq_write_data), .frq_full(frq_full),
        .fin_write_en(fin_write_en), .fin_write_data(fin_write_data), .fin_full(fin_full),
        .fout_read_en(fout_read_en), .fout_read_data(fout_read_data), .fout_empty(fout_empty),
        .busy(busy), .done(done), .error(error), .err_count(err_count), .err_addr(err_addr)
    );

    // Environment model state
    logic [LRS-1:0] reqq[$];
    logic [PL-1:0]  wdq[$];
    logic [PL-1:0]  rdq[$];
    logic [PL-1:0]  mem [N];
    bit             corrupt [N];
    logic [LRS-1:0] req_log[$];
    logic [PL-1:0]  wdat_log[$];
    int             wr_cyc[$];
    int cyc = 0, cap = 64, stall_pct = 0, bp_pct = 0, proto_bad = 0, rd_cnt = 0;
    int reqq_n = 0, wdq_n = 0;
    bit force_full = 0, rnd_frq = 0, rnd_fin = 0;
    bit frq_full_q, fin_full_q, fout_empty_q, rst_q;
    int total = 0, bad = 0;

    assign frq_full = force_full | rnd_frq | (reqq_n >= cap);
    assign fin_full = rnd_fin | (wdq_n >= cap);

    // What the DUT saw at each active edge
    always @(posedge clk) begin
        frq_full_q   <= frq_full;
        fin_full_q   <= fin_full;
        fout_empty_q <= fout_empty;
        rst_q        <= rst;
    end

    // FIFOs + responder, evaluated on the falling edge
    always @(negedge clk) begin : model
        logic [LRS-1:0] r;
        int a;
        cyc++;
        if (rst_q) begin
            reqq.delete(); wdq.delete(); rdq.delete();
        end else begin
            if (frq_write_en) begin
                if (frq_full_q) proto_bad++;
                reqq.push_back(frq_write_data);
                req_log.push_back(frq_write_data);
                if (frq_write_data[0]) wr_cyc.push_back(cyc);
                else rd_cnt++;
            end
            if (fin_write_en) begin
                if (fin_full_q) proto_bad++;
                wdq.push_back(fin_write_data);
                wdat_log.push_back(fin_write_data);
            end
            if (fout_read_en) begin
                if (fout_empty_q || rdq.size() == 0) proto_bad++;
                else void'(rdq.pop_front());
            end
            if (reqq.size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
                r = reqq[0];
                a = int'(r[LRS-1:1]);
                if (r[0]) begin
                    if (wdq.size() > 0) begin
                        mem[a] = wdq.pop_front();
                        void'(reqq.pop_front());
                    end
                end else begin
                    rdq.push_back(corrupt[a] ? 32'hDEAD : mem[a]);
                    void'(reqq.pop_front());
                end
            end
        end
        reqq_n = reqq.size();
        wdq_n  = wdq.size();
        rnd_frq = ($urandom_range(0, 99) < bp_pct);
        rnd_fin = ($urandom_range(0, 99) < bp_pct);
        fout_empty     = (rdq.size() == 0);
        fout_read_data = (rdq.size() != 0) ? rdq[0] : '0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        req_log.delete(); wdat_log.delete(); wr_cyc.delete(); rd_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    endtask

    // Reference: N writes {a,1} with data a, then N reads {a,0}; errors are
    // the corrupted pages, first reported at the lowest corrupted address.
    task automatic check_run(input string tag);
        int nmis = 0, nerr = 0, first = -1;
        for (int a = 0; a < N; a++) begin
            if (req_log.size() == 2*N) begin
                if (req_log[a]   !== LRS'({a, 1'b1})) nmis++;
                if (req_log[N+a] !== LRS'({a, 1'b0})) nmis++;
            end
            if (wdat_log.size() == N && wdat_log[a] !== PL'(a)) nmis++;
            if (corrupt[a]) begin nerr++; if (first < 0) first = a; end
        end
        chk({tag, "_req_count"}, 64'(req_log.size()), 64'(2*N));
        chk({tag, "_wdat_count"}, 64'(wdat_log.size()), 64'(N));
        chk({tag, "_seq_mismatch"}, 64'(nmis), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'(nerr > 0));
        chk({tag, "_err_count"}, 64'(err_count), 64'(nerr));
        if (nerr > 0) chk({tag, "_err_addr"}, 64'(err_addr), 64'(first));
        chk({tag, "_protocol"}, 64'(proto_bad), 64'd0);
    endtask

    initial begin
        int span, n;
        for (int a = 0; a < N; a++) begin corrupt[a] = 0; mem[a] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_frq_en", 64'(frq_write_en), 64'd0);
        chk("rst_fin_en", 64'(fin_write_en), 64'd0);
        chk("rst_fout_en", 64'(fout_read_en), 64'd0);
        chk("rst_busy_done_err", 64'({busy, done, error}), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);

        // No backpressure: writes back to back
        pulse_start();
        chk("nobp_busy", 64'(busy), 64'd1);
        wait_done("nobp");
        check_run("nobp");
        span = (wr_cyc.size() == N) ? wr_cyc[N-1] - wr_cyc[0] : -1;
        chk("nobp_write_span", 64'(span), 64'(N-1));

        // frq_full held for 8 cycles after the first two writes
        pulse_start();
        repeat (2) @(negedge clk);
        force_full = 1'b1;
        repeat (8) @(negedge clk);
        force_full = 1'b0;
        wait_done("hold");
        check_run("hold");
        span = (wr_cyc.size() == N) ? wr_cyc[N-1] - wr_cyc[0] : -1;
        chk("hold_write_span", 64'(span), 64'(N-1+8));

        // Page 5 corrupted, then a clean run clears the error
        corrupt[5] = 1;
        pulse_start();
        wait_done("bad5");
        check_run("bad5");
        corrupt[5] = 0;
        pulse_start();
        chk("restart_clears_error", 64'(error), 64'd0);
        wait_done("clean");
        check_run("clean");

        // Reset in the middle of the read pass
        stall_pct = 30;
        pulse_start();
        n = 0;
        while (rd_cnt < 3 && n < 500) begin @(negedge clk); n++; end
        chk("midrd_reached", 64'(rd_cnt >= 3), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrd_strobes", 64'({frq_write_en, fin_write_en, fout_read_en}), 64'd0);
        chk("midrd_busy_done", 64'({busy, done}), 64'd0);
        chk("midrd_error", 64'(error), 64'd0);
        repeat (2) @(negedge clk);
        pulse_start();
        wait_done("after_rst");
        check_run("after_rst");

        // start while busy is ignored
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("dbl_start");
        check_run("dbl_start");

        // Randomized stalls, backpressure and corrupted pages
        for (int it = 0; it < 4; it++) begin
            stall_pct = $urandom_range(0, 60);
            bp_pct    = $urandom_range(0, 40);
            for (int a = 0; a < N; a++) corrupt[a] = ($urandom_range(0, 5) == 0);
            pulse_start();
            wait_done("rand");
            check_run("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
